// File: rtl/sreg_tx_pkg.sv
// Shared definitions for the shift-register transmit sequencer:
// register mode encodings, sequencer states and the length-field width helper.
package sreg_tx_pkg;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;

    typedef enum logic {
        IDLE,
        SHIFT
    } tx_state_t;

    // Width of a field able to hold the values 0..n.
    function automatic int len_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sreg_tx_sequencer.sv
// Frame-transmit sequencer: loads parallel words into an external bidirectional
// shift register and steers it so the word leaves serially, MSB- or LSB-first.
module sreg_tx_sequencer
    import sreg_tx_pkg::*;
#(
    parameter int   N    = 8,
    parameter logic FILL = 1'b1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [N-1:0]           tx_data,
    input  logic                   tx_dir,
    input  logic [len_width(N)-1:0] tx_len,
    output logic [1:0]             M,
    output logic [N-1:0]           p_load,
    output logic                   Din_R,
    output logic                   Din_L,
    input  logic                   sr_dout_r,
    input  logic                   sr_dout_l,
    output logic                   ser_out,
    output logic                   ser_valid,
    output logic                   sof,
    output logic                   eof
);

    localparam int LW = len_width(N);

    tx_state_t       state, state_nxt;
    logic [LW-1:0]   cnt, cnt_nxt;
    logic            dir, dir_nxt;
    logic            first, first_nxt;
    logic            accept;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
            first <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
            first <= first_nxt;
        end
    end

    // The register has no hold mode, so every non-load cycle shifts; FILL is fed
    // into both serial inputs so idle cycles flush the register to the line level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        first_nxt = 1'b0;
        tx_ready  = 1'b1;
        M         = MODE_SHR;
        Din_R     = FILL;
        Din_L     = FILL;
        ser_out   = FILL;
        ser_valid = 1'b0;
        sof       = 1'b0;
        eof       = 1'b0;
        accept    = 1'b0;

        case (state)
            IDLE: begin
            end
            SHIFT: begin
                ser_out   = dir ? sr_dout_l : sr_dout_r;
                ser_valid = 1'b1;
                sof       = first;
                if (cnt != '0) begin
                    M        = dir ? MODE_SHL : MODE_SHR;
                    cnt_nxt  = cnt - 1'b1;
                    tx_ready = 1'b0;
                end else begin
                    eof       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Accepting during the eof cycle chains the next frame with no gap.
        accept = tx_valid && tx_ready;
        if (accept) begin
            M         = MODE_LOAD;
            state_nxt = SHIFT;
            dir_nxt   = tx_dir;
            first_nxt = 1'b1;
            cnt_nxt   = (tx_len == '0) ? LW'(N - 1) : tx_len - 1'b1;
        end

        p_load = (M == MODE_LOAD) ? tx_data : '0;
    end

endmodule

// File: tb/tb_sreg_tx_sequencer.sv
// Directed bench for sreg_tx_sequencer closed around a behavioural model of the
// bidirectional shift register it controls.
module tb_sreg_tx_sequencer;

    logic       clk;
    logic       clr;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_dir;
    logic [3:0] tx_len;
    logic [1:0] M;
    logic [7:0] p_load;
    logic       Din_R;
    logic       Din_L;
    logic       sr_dout_r;
    logic       sr_dout_l;
    logic       ser_out;
    logic       ser_valid;
    logic       sof;
    logic       eof;

    logic [7:0] sr_q;

    int n_cmp = 0;
    int n_err = 0;

    sreg_tx_sequencer #(.N(8), .FILL(1'b1)) dut (
        .clk       (clk),
        .clr       (clr),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_dir    (tx_dir),
        .tx_len    (tx_len),
        .M         (M),
        .p_load    (p_load),
        .Din_R     (Din_R),
        .Din_L     (Din_L),
        .sr_dout_r (sr_dout_r),
        .sr_dout_l (sr_dout_l),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .sof       (sof),
        .eof       (eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register: SHR moves toward the MSB and exits on Dout_R, SHL moves
    // toward the LSB and exits on Dout_L.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sr_q <= 8'h00;
        end else begin
            case (M)
                2'b00:   sr_q <= p_load;
                2'b01:   sr_q <= {Din_L, sr_q[7:1]};
                2'b10:   sr_q <= {sr_q[6:0], Din_R};
                default: sr_q <= sr_q;
            endcase
        end
    end

    assign sr_dout_r = sr_q[7];
    assign sr_dout_l = sr_q[0];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input string tag);
        tick();
        tx_valid = 1'b0;
        #1;
        checkOutput({tag, " ser_out"}, ser_out, 1'b1);
        checkOutput({tag, " ser_valid"}, ser_valid, 1'b0);
        checkOutput({tag, " tx_ready"}, tx_ready, 1'b1);
        checkOutput({tag, " M"}, M, 2'b10);
        checkOutput({tag, " sof_eof"}, {sof, eof}, 2'b00);
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] data, input logic dir, input logic [3:0] len);
        tick();
        tx_valid = 1'b1;
        tx_data  = data;
        tx_dir   = dir;
        tx_len   = len;
        #1;
        checkOutput({tag, " accept tx_ready"}, tx_ready, 1'b1);
        checkOutput({tag, " accept M"}, M, 2'b00);
        checkOutput({tag, " accept p_load"}, p_load, data);
    endtask

    // Walks one frame; bits holds the expected line bits left-aligned in send order.
    task automatic shiftFrame(input string tag, input logic [7:0] bits, input int n, input logic fdir,
                              input logic nv, input logic [7:0] nd, input logic ndir, input logic [3:0] nl);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == n - 1) begin
                tx_valid = nv;
                tx_data  = nd;
                tx_dir   = ndir;
                tx_len   = nl;
            end else begin
                tx_valid = 1'b1;
                tx_data  = ~tx_data;
                tx_dir   = ~tx_dir;
                tx_len   = 4'd3;
            end
            #1;
            checkOutput($sformatf("%s bit%0d ser_out", tag, i), ser_out, bits[7-i]);
            checkOutput($sformatf("%s bit%0d ser_valid", tag, i), ser_valid, 1'b1);
            checkOutput($sformatf("%s bit%0d sof", tag, i), sof, (i == 0));
            checkOutput($sformatf("%s bit%0d eof", tag, i), eof, (i == n - 1));
            checkOutput($sformatf("%s bit%0d tx_ready", tag, i), tx_ready, (i == n - 1));
            if (i < n - 1)
                checkOutput($sformatf("%s bit%0d M", tag, i), M, fdir ? 2'b01 : 2'b10);
            else
                checkOutput($sformatf("%s bit%0d M", tag, i), M, nv ? 2'b00 : 2'b10);
            checkOutput($sformatf("%s bit%0d p_load", tag, i), p_load, (i == n - 1 && nv) ? nd : 8'h00);
        end
    endtask

    initial begin
        clr      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_dir   = 1'b0;
        tx_len   = 4'd0;
        #2;
        checkOutput("reset ser_out", ser_out, 1'b1);
        checkOutput("reset ser_valid", ser_valid, 1'b0);
        checkOutput("reset tx_ready", tx_ready, 1'b1);
        checkOutput("reset M", M, 2'b10);
        checkOutput("reset p_load", p_load, 8'h00);
        checkOutput("reset din", {Din_R, Din_L}, 2'b11);
        checkOutput("reset sof_eof", {sof, eof}, 2'b00);
        tick();
        tick();
        clr = 1'b0;

        for (int i = 0; i < 10; i++) idleCycle($sformatf("idle%0d", i));

        // Full MSB-first frame, len 0 meaning 8.
        applyStimulus("a5msb", 8'hA5, 1'b0, 4'd0);
        shiftFrame("a5msb", 8'hA5, 8, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        idleCycle("after_a5msb");

        // Partial LSB-first frame.
        applyStimulus("a5lsb4", 8'hA5, 1'b1, 4'd4);
        shiftFrame("a5lsb4", 8'b1010_0000, 4, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        idleCycle("after_a5lsb4");

        // Back-to-back frames with a direction change.
        applyStimulus("b2b0", 8'hF0, 1'b0, 4'd8);
        shiftFrame("b2b0", 8'b1111_0000, 8, 1'b0, 1'b1, 8'h0F, 1'b1, 4'd8);
        shiftFrame("b2b1", 8'b1111_0000, 8, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0);
        idleCycle("after_b2b");

        // Abort during bit 3 of an A5 frame.
        applyStimulus("abort", 8'hA5, 1'b0, 4'd8);
        for (int i = 0; i < 3; i++) begin
            tick();
            tx_valid = 1'b0;
            #1;
            checkOutput($sformatf("abort bit%0d ser_out", i), ser_out, (i != 1));
        end
        tick();
        #1;
        checkOutput("abort bit3 pre ser_valid", ser_valid, 1'b1);
        clr = 1'b1;
        #1;
        checkOutput("abort ser_valid", ser_valid, 1'b0);
        checkOutput("abort ser_out", ser_out, 1'b1);
        checkOutput("abort tx_ready", tx_ready, 1'b1);
        checkOutput("abort M", M, 2'b10);
        checkOutput("abort sof_eof", {sof, eof}, 2'b00);
        #2;
        clr = 1'b0;
        idleCycle("post_abort0");
        idleCycle("post_abort1");

        applyStimulus("x81", 8'h81, 1'b0, 4'd0);
        shiftFrame("x81", 8'h81, 8, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
        idleCycle("after_x81");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sreg_tx_sequencer.md
# sreg_tx_sequencer

Frame-transmit sequencer for the N-bit bidirectional shift register with parallel load. It accepts parallel words through a valid/ready handshake, loads each word into the register, and shifts it out serially, MSB-first or LSB-first, one bit per clock. It drives the register's mode select, parallel-load bus and serial inputs, and observes both serial outputs. It supports back-to-back frames with no idle gap.

## Interface
Parameters:
- N, 8, register width; must match the controlled shift register
- FILL, 1'b1, line level driven on ser_out and into the register serial inputs when no frame is active

Ports:
- clk  in  1  rising-edge clock, shared with the shift register
- clr  in  1  asynchronous, active-high reset, shared with the shift register
- tx_valid  in  1  word offered
- tx_ready  out  1  sequencer can accept a word this cycle
- tx_data  in  N  word to transmit
- tx_dir  in  1  0 = MSB-first (right shift, out on Dout_R); 1 = LSB-first (left shift, out on Dout_L)
- tx_len  in  $clog2(N+1)  bits to send, 1..N; 0 is treated as N
- M  out  2  register mode select
- p_load  out  N  register parallel-load bus
- Din_R  out  1  register right-shift serial input
- Din_L  out  1  register left-shift serial input
- sr_dout_r  in  1  register Dout_R
- sr_dout_l  in  1  register Dout_L
- ser_out  out  1  serial line
- ser_valid  out  1  ser_out carries a frame bit
- sof  out  1  first bit of a frame on ser_out
- eof  out  1  last bit of a frame on ser_out

## Operation
- Mode encoding: LOAD = 2'b00, SHL = 2'b01, SHR = 2'b10. 2'b11 is never driven.
- The register has no hold mode, so the register state advances on every clock edge.
- States:
  - IDLE: M = SHR, Din_R = Din_L = FILL (flushes the register to FILL), tx_ready = 1.
  - SHIFT: a frame is on the line.
- Accept: when tx_valid && tx_ready, M = LOAD and p_load = tx_data in that same cycle (combinational). At the edge, the register loads, and the sequencer latches dir, sets cnt = len-1 (len = N when tx_len = 0), and enters SHIFT.
- In SHIFT:
  - ser_out = (dir ? sr_dout_l : sr_dout_r) and ser_valid = 1.
  - sof = 1 on the first SHIFT cycle of each frame.
  - If cnt != 0: M = (dir ? SHL : SHR), the unused serial input = FILL, cnt decrements, and tx_ready = 0.
  - If cnt == 0: eof = 1 and tx_ready = 1. If tx_valid, a new LOAD occurs and SHIFT continues with the new frame. Otherwise M = SHR with FILL and the next state is IDLE.
- Outside SHIFT: ser_out = FILL and ser_valid = sof = eof = 0.
- p_load = tx_data whenever M = LOAD. Otherwise p_load = 0.
- tx_data, tx_dir and tx_len are sampled only at the accept edge. Later changes have no effect on the frame in flight.
- Partial frame (len < N): only the first len bits in the selected order are sent. The remaining register bits are discarded by the next LOAD or by the flush.

## Timing
- Reset values: state = IDLE, cnt = 0, ser_out = FILL, ser_valid = sof = eof = 0, tx_ready = 1, M = SHR, Din_R = Din_L = FILL, p_load = 0. clr also clears the register, so the first 1..N idle cycles after reset show FILL on ser_out through the gating, never register content.
- Latency: accept edge → first bit on ser_out in the next cycle. A frame occupies exactly len cycles.
- Back-to-back frames: accepting during the eof cycle makes the first bit of the next frame follow directly. Throughput is one frame per len cycles.
- A direction change between back-to-back frames is legal. dir is re-latched at each accept.
- clr asserted mid-frame aborts the frame immediately and asynchronously: outputs return to reset values. No eof is generated for the aborted frame.

## Structure
- The shared package holds the mode constants MODE_LOAD, MODE_SHL and MODE_SHR, the state enum {IDLE, SHIFT}, and the length width function.
- No sub-module. A single FSM plus a down-counter.
- A top-level wrapper, sreg_tx_top, instantiates this block together with the shift register for verification.

## Test plan
- Reset, then idle 10 cycles → ser_out = 1, ser_valid = 0, tx_ready = 1, M = 2'b10 every cycle.
- N=8, tx_data = 8'hA5, dir = 0, len = 0 → bits 1,0,1,0,0,1,0,1 on ser_out over 8 cycles; sof on bit 0, eof on bit 7.
- tx_data = 8'hA5, dir = 1, len = 4 → bits 1,0,1,0 (LSB-first); eof on the 4th bit; ready low for the first 3 bits.
- tx_valid held high with 8'hF0 (dir 0), then 8'h0F (dir 1), each len 8 → 16 contiguous valid bits 1111000011110000 with no gap; second sof coincides with the cycle after the first eof.
- clr pulsed during bit 3 of a frame → ser_valid = 0 and ser_out = FILL immediately; after release, a new frame (8'h81, dir 0) transmits correctly.
- tx_data changed during the frame after accept → transmitted bits match the value sampled at accept.
